sad6_best_select: RTL and testbench



---
 rtl/sad_pkg.sv | 31 +++
 rtl/sad6_best_select_if.sv | 38 +++
 rtl/sad_cand_min2.sv | 13 +
 rtl/sad6_best_select.sv | 123 ++++++++++++
 tb/tb_sad6_best_select.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared types for the SAD6 best-candidate selection stage.
package sad_pkg;

    localparam int VAL_W = 14;
    localparam int IDX_W = 16;

    // One candidate: SAD value, its search index and the thread it came from.
    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic [IDX_W-1:0] index;
        logic [1:0]       thread;
    } cand_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    function automatic cand_t make_cand(
        input logic [VAL_W-1:0] value,
        input logic [IDX_W-1:0] index,
        input logic [1:0]       thread
    );
        cand_t c;
        c.value  = value;
        c.index  = index;
        c.thread = thread;
        return c;
    endfunction

endpackage

// File: rtl/sad6_best_select_if.sv
// Candidate/result bundle between the SAD5->SAD6 register and the SAD6 stage.
interface sad6_best_select_if;
    import sad_pkg::*;

    logic             clear;
    logic             trigger;
    logic [VAL_W-1:0] t1_value, t2_value, t3_value, t4_value;
    logic [IDX_W-1:0] t1_index, t2_index, t3_index, t4_index;

    logic             result_valid;
    logic [VAL_W-1:0] result_value;
    logic [IDX_W-1:0] result_index;
    logic [1:0]       result_thread;

    logic             done;
    logic [VAL_W-1:0] best_value;
    logic [IDX_W-1:0] best_index;
    logic [1:0]       best_thread;

    // Upstream side: presents candidates and observes results.
    modport master (
        output clear, trigger,
        output t1_value, t2_value, t3_value, t4_value,
        output t1_index, t2_index, t3_index, t4_index,
        input  result_valid, result_value, result_index, result_thread,
        input  done, best_value, best_index, best_thread
    );

    // SAD6 stage side.
    modport slave (
        input  clear, trigger,
        input  t1_value, t2_value, t3_value, t4_value,
        input  t1_index, t2_index, t3_index, t4_index,
        output result_valid, result_value, result_index, result_thread,
        output done, best_value, best_index, best_thread
    );

endinterface

// File: rtl/sad_cand_min2.sv
// Combinational 2-way minimum; b only wins when strictly smaller, so a tie
// keeps a (the lower thread, the earlier wA, or the earlier accumulated search).
module sad_cand_min2
    import sad_pkg::*;
(
    input  cand_t a_i,
    input  cand_t b_i,
    output cand_t win_o
);

    assign win_o = (b_i.value < a_i.value) ? b_i : a_i;

endmodule

// File: rtl/sad6_best_select.sv
// SAD6 stage: 4->1 winner over a 2-stage compare pipeline, plus a running
// global minimum reported with a done pulse every NUM_SEARCHES searches.
module sad6_best_select
    import sad_pkg::*;
#(
    parameter int NUM_SEARCHES = 4
) (
    input  logic                clk,
    input  logic                rst,
    sad6_best_select_if.slave   bus
);

    localparam int CW = $clog2(NUM_SEARCHES + 1);

    cand_t          t1, t2, t3, t4;
    cand_t          wa_d, wb_d, w_d, acc_min;
    cand_t          wa_q, wb_q, res_q;
    cand_t          acc_q, acc_d, best_q, best_d;
    logic           trig_q, v1_q, res_valid_q;
    logic           acc_full_q, acc_full_d;
    logic [CW-1:0]  count_q, count_d;
    state_t         state_q, state_d;
    logic           accept;

    assign t1 = make_cand(bus.t1_value, bus.t1_index, 2'd0);
    assign t2 = make_cand(bus.t2_value, bus.t2_index, 2'd1);
    assign t3 = make_cand(bus.t3_value, bus.t3_index, 2'd2);
    assign t4 = make_cand(bus.t4_value, bus.t4_index, 2'd3);

    // Rising edge of the level trigger; trig_q resets high so a trigger
    // held through reset must fall and rise again before it counts.
    assign accept = bus.trigger & ~trig_q;

    sad_cand_min2 u_min_a   (.a_i(t1),    .b_i(t2),    .win_o(wa_d));
    sad_cand_min2 u_min_b   (.a_i(t3),    .b_i(t4),    .win_o(wb_d));
    sad_cand_min2 u_min_w   (.a_i(wa_q),  .b_i(wb_q),  .win_o(w_d));
    sad_cand_min2 u_min_acc (.a_i(acc_q), .b_i(res_q), .win_o(acc_min));

    // Compare pipeline: stage 1 holds wA/wB, stage 2 holds the per-search winner.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            trig_q      <= 1'b1;
            v1_q        <= 1'b0;
            wa_q        <= '0;
            wb_q        <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            trig_q      <= bus.trigger;
            v1_q        <= accept;
            res_valid_q <= v1_q;
            if (accept) begin
                wa_q <= wa_d;
                wb_q <= wb_d;
            end
            if (v1_q) begin
                res_q <= w_d;
            end
        end
    end

    // Accumulator / FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            acc_full_q <= 1'b0;
            count_q    <= '0;
            best_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_full_q <= acc_full_d;
            count_q    <= count_d;
            best_q     <= best_d;
        end
    end

    // Next-state: fold each registered result into the running minimum and
    // hand the final winner to best_* when the search count is reached.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        acc_full_d = acc_full_q;
        count_d    = count_q;
        best_d     = best_q;
        unique case (state_q)
            ACCUM: begin
                if (bus.clear) begin
                    acc_full_d = 1'b0;
                    count_d    = '0;
                end else if (res_valid_q) begin
                    acc_d      = acc_full_q ? acc_min : res_q;
                    acc_full_d = 1'b1;
                    count_d    = count_q + CW'(1);
                    if (count_q == CW'(NUM_SEARCHES - 1)) begin
                        state_d = DONE;
                        best_d  = acc_d;
                    end
                end
            end
            DONE: begin
                acc_full_d = 1'b0;
                count_d    = '0;
                state_d    = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    assign bus.result_valid  = res_valid_q;
    assign bus.result_value  = res_q.value;
    assign bus.result_index  = res_q.index;
    assign bus.result_thread = res_q.thread;
    assign bus.done          = (state_q == DONE);
    assign bus.best_value    = best_q.value;
    assign bus.best_index    = best_q.index;
    assign bus.best_thread   = best_q.thread;

endmodule

// File: tb/tb_sad6_best_select.sv
// Directed bench for sad6_best_select (NUM_SEARCHES = 4).
module tb_sad6_best_select;
    import sad_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses;

    always #5 clk = ~clk;

    sad6_best_select_if bus ();

    sad6_best_select #(.NUM_SEARCHES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cands(
        input logic [13:0] v1, input logic [13:0] v2, input logic [13:0] v3, input logic [13:0] v4,
        input logic [15:0] i1, input logic [15:0] i2, input logic [15:0] i3, input logic [15:0] i4
    );
        bus.t1_value = v1; bus.t2_value = v2; bus.t3_value = v3; bus.t4_value = v4;
        bus.t1_index = i1; bus.t2_index = i2; bus.t3_index = i3; bus.t4_index = i4;
    endtask

    task automatic check_best(input string tag, input logic [13:0] ev, input logic [15:0] ei, input logic [1:0] et);
        check({tag, ".best_value"},  32'(bus.best_value),  32'(ev));
        check({tag, ".best_index"},  32'(bus.best_index),  32'(ei));
        check({tag, ".best_thread"}, 32'(bus.best_thread), 32'(et));
    endtask

    // One search: rise trigger, expect the pulse two edges later, optionally
    // assert clear on the accumulate cycle, then check the done flag one cycle on.
    task automatic run_search(
        input string tag,
        input logic [13:0] v1, input logic [13:0] v2, input logic [13:0] v3, input logic [13:0] v4,
        input logic [15:0] i1, input logic [15:0] i2, input logic [15:0] i3, input logic [15:0] i4,
        input logic [13:0] ev, input logic [15:0] ei, input logic [1:0] et,
        input bit clr, input bit exp_done
    );
        set_cands(v1, v2, v3, v4, i1, i2, i3, i4);
        bus.trigger = 1'b1;
        tick();
        check({tag, ".rv_n1"}, 32'(bus.result_valid), 32'(0));
        bus.trigger = 1'b0;
        tick();
        check({tag, ".rv_n2"}, 32'(bus.result_valid), 32'(1));
        check({tag, ".value"},  32'(bus.result_value),  32'(ev));
        check({tag, ".index"},  32'(bus.result_index),  32'(ei));
        check({tag, ".thread"}, 32'(bus.result_thread), 32'(et));
        if (clr) bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check({tag, ".rv_n3"},      32'(bus.result_valid), 32'(0));
        check({tag, ".value_held"}, 32'(bus.result_value), 32'(ev));
        check({tag, ".done"},       32'(bus.done),         32'(exp_done));
    endtask

    initial begin
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.trigger = 1'b0;
        set_cands(14'd0, 14'd0, 14'd0, 14'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (3) tick();

        // Reset state.
        check("rst.result_valid", 32'(bus.result_valid), 32'(0));
        check("rst.result_value", 32'(bus.result_value), 32'(0));
        check("rst.done",         32'(bus.done),         32'(0));
        check_best("rst", 14'd0, 16'd0, 2'd0);
        rst = 1'b0;
        tick();

        // Group 1: basic winner, full tie, split tie; minimum 5 from search C.
        run_search("A", 14'd300, 14'd120, 14'd500, 14'd121, 16'd10, 16'd20, 16'd30, 16'd40,
                   14'd120, 16'd20, 2'd1, 1'b0, 1'b0);
        run_search("B", 14'd77, 14'd77, 14'd77, 14'd77, 16'd1, 16'd2, 16'd3, 16'd4,
                   14'd77, 16'd1, 2'd0, 1'b0, 1'b0);
        run_search("C", 14'd9, 14'd5, 14'd9, 14'd5, 16'd11, 16'd12, 16'd13, 16'd14,
                   14'd5, 16'd12, 2'd1, 1'b0, 1'b0);
        run_search("D", 14'd60, 14'd70, 14'd50, 14'd80, 16'd1, 16'd2, 16'd3, 16'd4,
                   14'd50, 16'd3, 2'd2, 1'b0, 1'b1);
        check_best("g1", 14'd5, 16'd12, 2'd1);
        tick();
        check("g1.done_one_cycle", 32'(bus.done), 32'(0));
        check_best("g1.hold", 14'd5, 16'd12, 2'd1);

        // Group 2: winners 200, 90, 90, 150; the earlier 90 must be kept.
        run_search("E", 14'd200, 14'd300, 14'd250, 14'd210, 16'd100, 16'd101, 16'd102, 16'd103,
                   14'd200, 16'd100, 2'd0, 1'b0, 1'b0);
        run_search("F", 14'd95, 14'd96, 14'd97, 14'd90, 16'd200, 16'd201, 16'd202, 16'd203,
                   14'd90, 16'd203, 2'd3, 1'b0, 1'b0);
        run_search("G", 14'd90, 14'd91, 14'd92, 14'd93, 16'd300, 16'd301, 16'd302, 16'd303,
                   14'd90, 16'd300, 2'd0, 1'b0, 1'b0);
        run_search("H", 14'd160, 14'd150, 14'd170, 14'd180, 16'd400, 16'd401, 16'd402, 16'd403,
                   14'd150, 16'd401, 2'd1, 1'b0, 1'b1);
        check_best("g2", 14'd90, 16'd203, 2'd3);

        // Group 3: clear on the 2nd accumulate; done only after 4 more searches.
        run_search("S1", 14'd10, 14'd20, 14'd30, 14'd40, 16'd1, 16'd2, 16'd3, 16'd4,
                   14'd10, 16'd1, 2'd0, 1'b0, 1'b0);
        run_search("S2", 14'd8, 14'd7, 14'd6, 14'd5, 16'd5, 16'd6, 16'd7, 16'd8,
                   14'd5, 16'd8, 2'd3, 1'b1, 1'b0);
        run_search("S3", 14'd40, 14'd50, 14'd40, 14'd60, 16'd31, 16'd32, 16'd33, 16'd34,
                   14'd40, 16'd31, 2'd0, 1'b0, 1'b0);
        run_search("S4", 14'd70, 14'd71, 14'd72, 14'd73, 16'd41, 16'd42, 16'd43, 16'd44,
                   14'd70, 16'd41, 2'd0, 1'b0, 1'b0);
        run_search("S5", 14'd80, 14'd81, 14'd82, 14'd83, 16'd51, 16'd52, 16'd53, 16'd54,
                   14'd80, 16'd51, 2'd0, 1'b0, 1'b0);
        run_search("S6", 14'd99, 14'd98, 14'd97, 14'd96, 16'd61, 16'd62, 16'd63, 16'd64,
                   14'd96, 16'd64, 2'd3, 1'b0, 1'b1);
        check_best("g3", 14'd40, 16'd31, 2'd0);

        // Held trigger: high 6, low 1, high again -> exactly two pulses.
        set_cands(14'd1000, 14'd1001, 14'd1002, 14'd1003, 16'd0, 16'd1, 16'd2, 16'd3);
        pulses = 0;
        bus.trigger = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); pulses += int'(bus.result_valid); end
        bus.trigger = 1'b0;
        tick(); pulses += int'(bus.result_valid);
        bus.trigger = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); pulses += int'(bus.result_valid); end
        bus.trigger = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); pulses += int'(bus.result_valid); end
        check("held.pulses", 32'(pulses), 32'(2));

        // Trigger high across reset deassertion -> no accept until it re-rises.
        rst = 1'b1;
        bus.trigger = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin tick(); pulses += int'(bus.result_valid); end
        check("rst_held.pulses", 32'(pulses), 32'(0));
        check("rst_held.result_value", 32'(bus.result_value), 32'(0));
        check_best("rst_held", 14'd0, 16'd0, 2'd0);
        bus.trigger = 1'b0;
        tick();
        run_search("R", 14'd700, 14'd800, 14'd600, 14'd900, 16'd7, 16'd8, 16'd6, 16'd9,
                   14'd600, 16'd6, 2'd2, 1'b0, 1'b0);

        // Reset one cycle after accept: candidate dropped, outputs and count cleared.
        set_cands(14'd1, 14'd2, 14'd3, 14'd4, 16'd1, 16'd2, 16'd3, 16'd4);
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin tick(); pulses += int'(bus.result_valid); end
        check("mid_rst.pulses",       32'(pulses),            32'(0));
        check("mid_rst.result_value", 32'(bus.result_value),  32'(0));
        check("mid_rst.result_index", 32'(bus.result_index),  32'(0));
        check("mid_rst.done",         32'(bus.done),          32'(0));

        // Four fresh searches: done must land on the 4th, proving count restarted at 0.
        for (int k = 0; k < 4; k++) begin
            run_search($sformatf("P%0d", k),
                       14'd600, 14'd600, 14'(500 - 50 * k), 14'd600,
                       16'd0, 16'd0, 16'(1000 + k), 16'd0,
                       14'(500 - 50 * k), 16'(1000 + k), 2'd2, 1'b0, k == 3);
        end
        check_best("post_rst", 14'd350, 16'd1003, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
